// File: rtl/prom_pkg.sv
// Shared types and constants for the one-time-programmable PROM programmer.
package prom_pkg;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 16;

   localparam logic [DATA_W-1:0] ERASED_VAL = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK,
      ST_PROGRAM,
      ST_VERIFY
   } state_e;

endpackage

// File: rtl/prom_array.sv
// 16x8 OTP storage: a write can only clear bits; two combinational read ports.
module prom_array
   import prom_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata,
   input  logic [ADDR_W-1:0] vaddr,
   output logic [DATA_W-1:0] vdata
);

   // Erased at power-up only; reset deliberately leaves the contents alone.
   logic [DATA_W-1:0] mem_q [DEPTH] = '{default: ERASED_VAL};
   logic [DATA_W-1:0] word_d;

   always_comb begin
      word_d = mem_q[waddr] & wdata;
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= word_d;
      end
   end

   always_comb begin
      rdata = mem_q[raddr];
      vdata = mem_q[vaddr];
   end

endmodule

// File: rtl/prom_programmer.sv
// Program/verify sequencer for the OTP array: check, pulse, verify, retry.
module prom_programmer
   import prom_pkg::*;
#(
   parameter int unsigned PULSE_CYCLES = 4,
   parameter int unsigned MAX_TRIES    = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pgm_inhibit,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);

   state_e            state_q, state_d;
   logic [3:0]        pulse_cnt_q, pulse_cnt_d;
   logic [2:0]        try_cnt_q, try_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              we;
   logic [DATA_W-1:0] vdata;

   prom_array u_array (
      .clk   (clk),
      .we    (we),
      .waddr (addr_q),
      .wdata (data_q),
      .raddr (rd_addr),
      .rdata (rd_data),
      .vaddr (addr_q),
      .vdata (vdata)
   );

   always_comb begin
      state_d     = state_q;
      pulse_cnt_d = pulse_cnt_q;
      try_cnt_d   = try_cnt_q;
      addr_d      = addr_q;
      data_d      = data_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      we          = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               addr_d    = wr_addr;
               data_d    = wr_data;
               try_cnt_d = '0;
               state_d   = ST_CHECK;
            end
         end
         ST_CHECK: begin
            // Any bit needing a 0->1 transition can never be programmed.
            if ((~vdata & data_q) != '0) begin
               done_d  = 1'b1;
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               pulse_cnt_d = '0;
               state_d     = ST_PROGRAM;
            end
         end
         ST_PROGRAM: begin
            if (pulse_cnt_q == PULSE_LAST) begin
               we      = ~pgm_inhibit & rst_n;
               state_d = ST_VERIFY;
            end else begin
               pulse_cnt_d = pulse_cnt_q + 4'd1;
            end
         end
         ST_VERIFY: begin
            if (vdata == data_q) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else if ((int'(try_cnt_q) + 1) < int'(MAX_TRIES)) begin
               try_cnt_d   = try_cnt_q + 3'd1;
               pulse_cnt_d = '0;
               state_d     = ST_PROGRAM;
            end else begin
               try_cnt_d = try_cnt_q + 3'd1;
               done_d    = 1'b1;
               err_d     = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         pulse_cnt_q <= '0;
         try_cnt_q   <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pulse_cnt_q <= pulse_cnt_d;
         try_cnt_q   <= try_cnt_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      busy = (state_q != ST_IDLE);
      done = done_q;
      err  = err_q;
   end

endmodule

// File: tb/tb_prom_programmer.sv
// Directed bench for prom_programmer: vector table of requests plus reset and back-to-back sequences.
module tb_prom_programmer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       pgm_inhibit;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic       busy;
   logic       done;
   logic       err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] addr;
      logic [7:0] data;
      int         mode;   // 0: no inhibit, 1: inhibit first pulse, 2: inhibit always
      logic [7:0] pre;
      int         lat;
      logic       err;
      logic [7:0] word;
   } vec_t;

   vec_t vecs[7];

   prom_programmer #(
      .PULSE_CYCLES (4),
      .MAX_TRIES    (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .pgm_inhibit (pgm_inhibit),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one request, wait for done (bounded), compare latency/status/word.
   task automatic run_req(input vec_t v, input string tag);
      int n;
      wr_addr     = v.addr;
      wr_data     = v.data;
      rd_addr     = v.addr;
      pgm_inhibit = (v.mode != 0);
      req         = 1'b1;
      tick();
      req = 1'b0;
      n   = 0;
      chk({tag, " busy_after_accept"}, 32'(busy), 32'd1);
      while (!done && n < 100) begin
         tick();
         n++;
         if (v.mode == 1 && n == 6) pgm_inhibit = 1'b0;
         if (v.mode == 0 && v.lat == 6 && n == 4) chk({tag, " rd_pre_commit"}, 32'(rd_data), 32'(v.pre));
         if (v.mode == 0 && v.lat == 6 && n == 5) chk({tag, " rd_post_commit"}, 32'(rd_data), 32'(v.word));
      end
      chk({tag, " latency"}, n, v.lat);
      chk({tag, " err"}, 32'(err), 32'(v.err));
      chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
      chk({tag, " word"}, 32'(rd_data), 32'(v.word));
      pgm_inhibit = 1'b0;
      tick();
      chk({tag, " done_one_cycle"}, 32'({done, err}), 32'd0);
   endtask

   initial begin
      vec_t v;
      int   n;

      vecs[0] = '{addr: 4'd3,  data: 8'hA1, mode: 0, pre: 8'hFF, lat: 6,  err: 1'b0, word: 8'hA1};
      vecs[1] = '{addr: 4'd3,  data: 8'hB2, mode: 0, pre: 8'hA1, lat: 1,  err: 1'b1, word: 8'hA1};
      vecs[2] = '{addr: 4'd5,  data: 8'h12, mode: 1, pre: 8'hFF, lat: 11, err: 1'b0, word: 8'h12};
      vecs[3] = '{addr: 4'd7,  data: 8'h34, mode: 2, pre: 8'hFF, lat: 16, err: 1'b1, word: 8'hFF};
      vecs[4] = '{addr: 4'd3,  data: 8'hA1, mode: 0, pre: 8'hA1, lat: 6,  err: 1'b0, word: 8'hA1};
      vecs[5] = '{addr: 4'd3,  data: 8'h21, mode: 0, pre: 8'hA1, lat: 6,  err: 1'b0, word: 8'h21};
      vecs[6] = '{addr: 4'd0,  data: 8'h00, mode: 0, pre: 8'hFF, lat: 6,  err: 1'b0, word: 8'h00};

      rst_n       = 1'b0;
      req         = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;
      pgm_inhibit = 1'b0;
      rd_addr     = 4'd0;
      tick();
      tick();
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset err", 32'(err), 32'd0);
      chk("erased word0", 32'(rd_data), 32'hFF);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) begin
         run_req(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset in the middle of a program pulse.
      wr_addr = 4'd9;
      wr_data = 8'h56;
      rd_addr = 4'd9;
      req     = 1'b1;
      tick();
      req = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst done", 32'(done), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("midrst word", 32'(rd_data), 32'hFF);
      chk("midrst idle", 32'(busy), 32'd0);
      v = '{addr: 4'd9, data: 8'h56, mode: 0, pre: 8'hFF, lat: 6, err: 1'b0, word: 8'h56};
      run_req(v, "post_rst");

      // Back-to-back: req held across the whole op and into the done cycle.
      wr_addr = 4'd10;
      wr_data = 8'h0F;
      rd_addr = 4'd10;
      req     = 1'b1;
      tick();
      wr_addr = 4'd11;
      wr_data = 8'h00;
      n = 0;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      chk("b2b first latency", n, 6);
      chk("b2b first err", 32'(err), 32'd0);
      chk("b2b first word", 32'(rd_data), 32'h0F);
      wr_addr = 4'd12;
      wr_data = 8'hF0;
      tick();
      chk("b2b second accepted", 32'(busy), 32'd1);
      chk("b2b done low", 32'(done), 32'd0);
      req = 1'b0;
      n = 0;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      chk("b2b second latency", n, 6);
      chk("b2b second err", 32'(err), 32'd0);
      rd_addr = 4'd12;
      #1;
      chk("b2b second word", 32'(rd_data), 32'hF0);
      rd_addr = 4'd11;
      #1;
      chk("b2b ignored word", 32'(rd_data), 32'hFF);
      tick();
      chk("b2b idle", 32'({busy, done}), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
